// File: rtl/clock_enable_gen_if.sv
// rtl/clock_enable_gen_if.sv - control/status bundle for clock_enable_gen
//  Purpose: groups the divisor programming strobes, sync request and the
//           per-channel enable/square outputs plus the free-running counter.
//  Ports (signals):
//    div_we, div_sel[SEL_W], div_val[CNT_W], sync_req   master -> slave
//    duty_we (only with CLKGEN_PWM_EN defined)          master -> slave
//    en_pulse[NUM_CH], clk_sq[NUM_CH], free_cnt[CNT_W]  slave  -> master
//  Optional feature macro: CLKGEN_PWM_EN
interface clock_enable_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26,
    parameter int SEL_W  = 2
) ();
    logic                 div_we;
    logic [SEL_W-1:0]     div_sel;
    logic [CNT_W-1:0]     div_val;
    logic                 sync_req;
`ifdef CLKGEN_PWM_EN
    logic                 duty_we;
`endif
    logic [NUM_CH-1:0]    en_pulse;
    logic [NUM_CH-1:0]    clk_sq;
    logic [CNT_W-1:0]     free_cnt;

    modport master (
        output div_we, div_sel, div_val, sync_req,
`ifdef CLKGEN_PWM_EN
        output duty_we,
`endif
        input  en_pulse, clk_sq, free_cnt
    );

    modport slave (
        input  div_we, div_sel, div_val, sync_req,
`ifdef CLKGEN_PWM_EN
        input  duty_we,
`endif
        output en_pulse, clk_sq, free_cnt
    );
endinterface

// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - multi-channel programmable clock-enable generator
//  Purpose: NUM_CH divider channels on one system clock, each giving a
//           one-cycle enable every d+1 cycles and a registered square wave.
//  Ports:
//    clk_in  system clock (posedge)
//    rst     synchronous reset, active-high
//    bus     clock_enable_gen_if.slave: div_we/div_sel/div_val/sync_req in,
//            en_pulse/clk_sq/free_cnt out (duty_we in with PWM)
//  Optional feature macro: CLKGEN_PWM_EN (clk_sq becomes c < duty PWM)
module clock_enable_gen #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 26,
    parameter int DIV_RESET = 1,
    parameter int SEL_W     = 2
) (
    input  logic               clk_in,
    input  logic               rst,
    clock_enable_gen_if.slave  bus
);
    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_RESET);
`ifdef CLKGEN_PWM_EN
    localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'((DIV_RESET + 1) / 2);
`endif

    logic [CNT_W-1:0]  d_q [NUM_CH];
    logic [CNT_W-1:0]  d_d [NUM_CH];
    logic [CNT_W-1:0]  s_q [NUM_CH];
    logic [CNT_W-1:0]  s_d [NUM_CH];
    logic [CNT_W-1:0]  c_q [NUM_CH];
    logic [CNT_W-1:0]  c_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic [CNT_W-1:0]  free_q, free_d;
    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] wr_hit;
`ifdef CLKGEN_PWM_EN
    logic [CNT_W-1:0]  dus_q [NUM_CH];
    logic [CNT_W-1:0]  dus_d [NUM_CH];
    logic [CNT_W-1:0]  dua_q [NUM_CH];
    logic [CNT_W-1:0]  dua_d [NUM_CH];
    logic [NUM_CH-1:0] duty_hit;
`endif

    always_comb begin
        free_d = free_q + CNT_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
            // A select value outside 0..NUM_CH-1 matches no channel and is dropped.
            wr_hit[i] = bus.div_we && (bus.div_sel == SEL_W'(i));
            tc[i]     = (c_q[i] == d_q[i]);
            s_d[i]    = wr_hit[i] ? bus.div_val : s_q[i];
`ifdef CLKGEN_PWM_EN
            duty_hit[i] = bus.duty_we && (bus.div_sel == SEL_W'(i));
            dus_d[i]    = duty_hit[i] ? bus.div_val : dus_q[i];
`endif
            if (bus.sync_req) begin
                // s_d lets a same-cycle write land directly in the active register.
                c_d[i]  = '0;
                d_d[i]  = s_d[i];
                en_d[i] = 1'b0;
                sq_d[i] = 1'b0;
`ifdef CLKGEN_PWM_EN
                dua_d[i] = dus_d[i];
`endif
            end else begin
                // Active values only move at terminal count, when c restarts at 0,
                // so c can never be stranded above a smaller new d.
                c_d[i]  = tc[i] ? '0 : c_q[i] + CNT_W'(1);
                d_d[i]  = tc[i] ? s_q[i] : d_q[i];
                en_d[i] = tc[i];
`ifdef CLKGEN_PWM_EN
                dua_d[i] = tc[i] ? dus_q[i] : dua_q[i];
                sq_d[i]  = (c_q[i] < dua_q[i]);
`else
                sq_d[i]  = tc[i] ? ~sq_q[i] : sq_q[i];
`endif
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_q[i] <= DIV_INIT;
                s_q[i] <= DIV_INIT;
                c_q[i] <= '0;
`ifdef CLKGEN_PWM_EN
                dus_q[i] <= DUTY_INIT;
                dua_q[i] <= DUTY_INIT;
`endif
            end
            en_q   <= '0;
            sq_q   <= '0;
            free_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_q[i] <= d_d[i];
                s_q[i] <= s_d[i];
                c_q[i] <= c_d[i];
`ifdef CLKGEN_PWM_EN
                dus_q[i] <= dus_d[i];
                dua_q[i] <= dua_d[i];
`endif
            end
            en_q   <= en_d;
            sq_q   <= sq_d;
            free_q <= free_d;
        end
    end

    assign bus.en_pulse = en_q;
    assign bus.clk_sq   = sq_q;
    assign bus.free_cnt = free_q;
endmodule
